cvxif_offload_master: RTL and testbench
=======================================

// Module: cvxif_offload_master
// PURPOSE
//  Core-side initiator of the CV-X-IF coprocessor interface. Takes one custom instruction
//  plus its two source operands from the core pipeline and offers it to the coprocessor
//  (e.g. the posit arithmetic unit). If the coprocessor accepts it, the block supplies the
//  operands, collects the result and returns a writeback record (rd, data) to the core.
//  One transaction is in flight at a time. A rejected instruction is reported as illegal.
// PARAMETERS
//  TIMEOUT_CYCLES  255  max cycles spent in REG+WAIT before abort; counter width $clog2(TIMEOUT_CYCLES+1)
//  REG_READY_USED  1    1: register phase ends on register_valid&&register_ready; 0: after 1 cycle of register_valid
// PORTS
//  clk                       in   1   clock, all state on rising edge
//  rst                       in   1   asynchronous, active-high reset
//  core_req_valid            in   1   core offers instruction+operands
//  core_req_ready            out  1   block can take a request (IDLE)
//  core_req_instr            in   32  instruction word
//  core_req_rs0/core_req_rs1 in   32  source operand values
//  core_resp_valid           out  1   completion record valid
//  core_resp_ready           in   1   core consumes completion
//  core_resp_illegal         out  1   coprocessor rejected instr or timeout
//  core_resp_timeout         out  1   abort caused by timeout (implies illegal)
//  core_resp_we              out  1   write core_resp_data to rd
//  core_resp_rd              out  5   destination register = instr[11:7]
//  core_resp_data            out  32  result value
//  issue_valid               out  1   instruction offered to coprocessor
//  issue_ready               in   1   coprocessor samples issue this cycle
//  issue_req_instr           out  32  latched instruction
//  issue_resp_accept         in   1   valid in issue handshake cycle
//  issue_resp_writeback      in   1   valid in issue handshake cycle
//  issue_resp_register_read  in   2   valid in issue handshake cycle; operands wanted
//  register_valid            out  1   operands valid
//  register_ready            in   1   coprocessor takes operands
//  register_rs0/register_rs1 out  32  latched operands
//  register_rs_valid         out  2   = latched issue_resp_register_read
//  result_valid              in   1   coprocessor result valid
//  result_ready              out  1   block accepts result (high in WAIT)
//  result_data               in   32  result value
// BEHAVIOUR
//  States: IDLE, ISSUE, REG, WAIT, RESP. Reset -> IDLE; all outputs 0, latches and counter 0.
//  IDLE: core_req_ready=1. On core_req_valid latch instr/rs0/rs1 -> ISSUE (next cycle).
//  ISSUE: issue_valid=1, issue_req_instr stable until issue_ready. On issue_ready sample
//   accept/writeback/register_read. accept=0 -> RESP, illegal=1, we=0. accept=1 -> REG,
//   latch writeback, register_rs_valid; clear timeout counter. No timeout in ISSUE.
//  REG: register_valid=1 with rs0/rs1/rs_valid stable. Completion per REG_READY_USED ->
//   WAIT if writeback=1, else RESP with we=0, illegal=0.
//  WAIT: result_ready=1. On result_valid capture result_data -> RESP, we=1, illegal=0.
//  Timeout: counter increments each cycle in REG/WAIT; reaching TIMEOUT_CYCLES aborts ->
//   RESP, illegal=1, timeout=1, we=0; handshake completing in that same cycle wins.
//  RESP: core_resp_valid=1, fields stable until core_resp_ready -> IDLE; no new request
//   taken in that cycle (min 5 cycles request-to-response with 0-wait coprocessor).
//  core_resp_rd always instr[11:7]. core_resp_data 0 when we=0.
//  Outputs decoded from registered state/latches only; no in->out combinational path.
//  Reset mid-transaction aborts silently: no core response, all valids drop asynchronously.
// TESTING
//  Accepting model, writeback=1, rd=5, result 0x00004000 at 2nd WAIT cycle -> core_resp we=1 rd=5 data=0x00004000.
//  issue_ready held low 10 cycles -> issue_valid/instr stable throughout, no timeout, completes normally.
//  issue_resp_accept=0 -> core_resp_valid with illegal=1, we=0; register_valid never asserted.
//  REG_READY_USED=0, register_ready tied 0 -> register_valid exactly 1 cycle, then WAIT.
//  TIMEOUT_CYCLES=8, result never valid -> abort 8 cycles after entering REG, illegal=1 timeout=1.
//  core_resp_ready low 4 cycles, then rst pulse mid-WAIT -> response stable, then all outputs 0, IDLE.

Source files
------------

// File: rtl/cvxif_offload_master.sv
// Core-side CV-X-IF initiator: issues one custom instruction to a coprocessor, supplies its
// operands, collects the result and hands a writeback record back to the core.
module cvxif_offload_master #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter bit REG_READY_USED = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        core_req_valid,
  output logic        core_req_ready,
  input  logic [31:0] core_req_instr,
  input  logic [31:0] core_req_rs0,
  input  logic [31:0] core_req_rs1,
  output logic        core_resp_valid,
  input  logic        core_resp_ready,
  output logic        core_resp_illegal,
  output logic        core_resp_timeout,
  output logic        core_resp_we,
  output logic [4:0]  core_resp_rd,
  output logic [31:0] core_resp_data,
  output logic        issue_valid,
  input  logic        issue_ready,
  output logic [31:0] issue_req_instr,
  input  logic        issue_resp_accept,
  input  logic        issue_resp_writeback,
  input  logic [1:0]  issue_resp_register_read,
  output logic        register_valid,
  input  logic        register_ready,
  output logic [31:0] register_rs0,
  output logic [31:0] register_rs1,
  output logic [1:0]  register_rs_valid,
  input  logic        result_valid,
  output logic        result_ready,
  input  logic [31:0] result_data,
  output logic [2:0]  state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // the valid side holds its payload stable until then and never waits on ready.
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_REG, S_WAIT, S_RESP} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] tmo_cnt;
  logic [31:0]   instr_q, rs0_q, rs1_q, data_q;
  logic          wb_q, illegal_q, timeout_q, we_q;
  logic [1:0]    rs_valid_q;
  logic          tmo_hit, reg_done;

  // tmo_hit marks the last permitted cycle of REG+WAIT; a handshake in it still wins.
  assign tmo_hit  = (tmo_cnt == TMO_LAST);
  assign reg_done = REG_READY_USED ? register_ready : 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (core_req_valid) state_nxt = S_ISSUE;
      S_ISSUE: if (issue_ready) state_nxt = issue_resp_accept ? S_REG : S_RESP;
      S_REG: begin
        if (reg_done)     state_nxt = wb_q ? S_WAIT : S_RESP;
        else if (tmo_hit) state_nxt = S_RESP;
      end
      S_WAIT:  if (result_valid || tmo_hit) state_nxt = S_RESP;
      S_RESP:  if (core_resp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt    <= '0;
      instr_q    <= '0;
      rs0_q      <= '0;
      rs1_q      <= '0;
      data_q     <= '0;
      wb_q       <= 1'b0;
      illegal_q  <= 1'b0;
      timeout_q  <= 1'b0;
      we_q       <= 1'b0;
      rs_valid_q <= '0;
    end else begin
      case (state)
        S_IDLE: if (core_req_valid) begin
          instr_q    <= core_req_instr;
          rs0_q      <= core_req_rs0;
          rs1_q      <= core_req_rs1;
          data_q     <= '0;
          wb_q       <= 1'b0;
          illegal_q  <= 1'b0;
          timeout_q  <= 1'b0;
          we_q       <= 1'b0;
          rs_valid_q <= '0;
        end
        S_ISSUE: if (issue_ready) begin
          if (issue_resp_accept) begin
            wb_q       <= issue_resp_writeback;
            rs_valid_q <= issue_resp_register_read;
            tmo_cnt    <= '0;
          end else begin
            illegal_q <= 1'b1;
          end
        end
        S_REG: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (!reg_done && tmo_hit) begin
            illegal_q <= 1'b1;
            timeout_q <= 1'b1;
          end
        end
        S_WAIT: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (result_valid) begin
            data_q <= result_data;
            we_q   <= 1'b1;
          end else if (tmo_hit) begin
            illegal_q <= 1'b1;
            timeout_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Every output comes from state or a latch, never straight from an input.
  always_comb begin
    core_req_ready    = (state == S_IDLE);
    issue_valid       = (state == S_ISSUE);
    register_valid    = (state == S_REG);
    result_ready      = (state == S_WAIT);
    core_resp_valid   = (state == S_RESP);
    issue_req_instr   = instr_q;
    register_rs0      = rs0_q;
    register_rs1      = rs1_q;
    register_rs_valid = rs_valid_q;
    core_resp_illegal = illegal_q;
    core_resp_timeout = timeout_q;
    core_resp_we      = we_q;
    core_resp_rd      = instr_q[11:7];
    core_resp_data    = data_q;
    state_dbg         = state;
  end

endmodule

// File: tb/tb_cvxif_offload_master.sv
// Bench for cvxif_offload_master: two instances (ready-gated and one-cycle register phase)
// driven by a reactive coprocessor model, with outcomes predicted from cycle arithmetic.
module tb_cvxif_offload_master;
  localparam int T_A = 12;
  localparam int T_B = 8;

  typedef struct packed {
    logic        core_req_ready;
    logic        core_resp_valid;
    logic        core_resp_illegal;
    logic        core_resp_timeout;
    logic        core_resp_we;
    logic [4:0]  core_resp_rd;
    logic [31:0] core_resp_data;
    logic        issue_valid;
    logic [31:0] issue_req_instr;
    logic        register_valid;
    logic [31:0] register_rs0;
    logic [31:0] register_rs1;
    logic [1:0]  register_rs_valid;
    logic        result_ready;
    logic [2:0]  state_dbg;
  } dut_out_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_req_valid, core_resp_ready, issue_ready, issue_resp_accept;
  logic        issue_resp_writeback, register_ready, result_valid;
  logic [1:0]  issue_resp_register_read;
  logic [31:0] core_req_instr, core_req_rs0, core_req_rs1, result_data;
  logic        sel;
  dut_out_t    oa, ob, o;
  int          checks = 0;
  int          failures = 0;

  assign o = sel ? ob : oa;
  always #5 clk = ~clk;

  cvxif_offload_master #(.TIMEOUT_CYCLES(T_A), .REG_READY_USED(1'b1)) dut_a (
    .clk(clk), .rst(rst),
    .core_req_valid(core_req_valid), .core_req_ready(oa.core_req_ready),
    .core_req_instr(core_req_instr), .core_req_rs0(core_req_rs0), .core_req_rs1(core_req_rs1),
    .core_resp_valid(oa.core_resp_valid), .core_resp_ready(core_resp_ready),
    .core_resp_illegal(oa.core_resp_illegal), .core_resp_timeout(oa.core_resp_timeout),
    .core_resp_we(oa.core_resp_we), .core_resp_rd(oa.core_resp_rd),
    .core_resp_data(oa.core_resp_data),
    .issue_valid(oa.issue_valid), .issue_ready(issue_ready),
    .issue_req_instr(oa.issue_req_instr), .issue_resp_accept(issue_resp_accept),
    .issue_resp_writeback(issue_resp_writeback),
    .issue_resp_register_read(issue_resp_register_read),
    .register_valid(oa.register_valid), .register_ready(register_ready),
    .register_rs0(oa.register_rs0), .register_rs1(oa.register_rs1),
    .register_rs_valid(oa.register_rs_valid),
    .result_valid(result_valid), .result_ready(oa.result_ready), .result_data(result_data),
    .state_dbg(oa.state_dbg)
  );

  cvxif_offload_master #(.TIMEOUT_CYCLES(T_B), .REG_READY_USED(1'b0)) dut_b (
    .clk(clk), .rst(rst),
    .core_req_valid(core_req_valid), .core_req_ready(ob.core_req_ready),
    .core_req_instr(core_req_instr), .core_req_rs0(core_req_rs0), .core_req_rs1(core_req_rs1),
    .core_resp_valid(ob.core_resp_valid), .core_resp_ready(core_resp_ready),
    .core_resp_illegal(ob.core_resp_illegal), .core_resp_timeout(ob.core_resp_timeout),
    .core_resp_we(ob.core_resp_we), .core_resp_rd(ob.core_resp_rd),
    .core_resp_data(ob.core_resp_data),
    .issue_valid(ob.issue_valid), .issue_ready(issue_ready),
    .issue_req_instr(ob.issue_req_instr), .issue_resp_accept(issue_resp_accept),
    .issue_resp_writeback(issue_resp_writeback),
    .issue_resp_register_read(issue_resp_register_read),
    .register_valid(ob.register_valid), .register_ready(register_ready),
    .register_rs0(ob.register_rs0), .register_rs1(ob.register_rs1),
    .register_rs_valid(ob.register_rs_valid),
    .result_valid(result_valid), .result_ready(ob.result_ready), .result_data(result_data),
    .state_dbg(ob.state_dbg)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // One full transaction. di: cycles issue_ready stays low; dr: cycles register_ready stays low;
  // dw: cycles result_valid stays low; rdly: cycles core_resp_ready stays low.
  task automatic run_txn(input logic [31:0] instr, input logic [31:0] rs0, input logic [31:0] rs1,
                         input logic acc, input logic wb, input logic [1:0] rr,
                         input int di, input int dr, input int dw, input int rdly,
                         input logic [31:0] res);
    int cyc, regc, waitc, r, done, m, t, exp_regc, exp_waitc;
    logic e_ill, e_to, e_we;
    logic [31:0] e_data;
    bit rru;
    // Reference outcome: REG+WAIT is allowed t cycles; whichever of completion or t comes first.
    t = sel ? T_B : T_A;
    rru = !sel;
    r = rru ? dr + 1 : 1;
    e_ill = !acc; e_to = 1'b0; e_we = 1'b0; e_data = '0;
    exp_regc = 0; exp_waitc = 0; m = 0;
    if (acc) begin
      if (r > t) begin
        e_ill = 1'b1; e_to = 1'b1; m = t; exp_regc = t;
      end else begin
        exp_regc = r; m = r;
        if (wb) begin
          done = r + dw + 1;
          if (done > t) begin
            e_ill = 1'b1; e_to = 1'b1; m = t;
          end else begin
            e_we = 1'b1; e_data = res; m = done;
          end
          exp_waitc = m - r;
        end
      end
    end

    chk("req_ready_idle", o.core_req_ready, 1);
    core_req_valid = 1'b1; core_req_instr = instr; core_req_rs0 = rs0; core_req_rs1 = rs1;
    @(negedge clk);
    core_req_valid = 1'b0; core_req_instr = $urandom; core_req_rs0 = $urandom;
    cyc = 1;
    for (int k = 0; k <= di; k++) begin
      chk("issue_valid", o.issue_valid, 1);
      chk("issue_instr", o.issue_req_instr, instr);
      issue_ready = (k == di);
      issue_resp_accept = (k == di) ? acc : 1'($urandom);
      issue_resp_writeback = (k == di) ? wb : 1'($urandom);
      issue_resp_register_read = (k == di) ? rr : 2'($urandom);
      @(negedge clk);
      cyc++;
    end
    issue_ready = 1'b0;
    regc = 0; waitc = 0;
    while (!o.core_resp_valid && cyc < 64) begin
      register_ready = 1'b0; result_valid = 1'b0;
      if (o.register_valid) begin
        regc++;
        chk("reg_rs0", o.register_rs0, rs0);
        chk("reg_rs1", o.register_rs1, rs1);
        chk("reg_rs_valid", o.register_rs_valid, rr);
        register_ready = (regc == dr + 1);
      end
      if (o.result_ready) begin
        waitc++;
        result_valid = (waitc == dw + 1);
        result_data = result_valid ? res : $urandom;
      end
      @(negedge clk);
      cyc++;
    end
    register_ready = 1'b0; result_valid = 1'b0;
    chk("resp_latency", cyc, 2 + di + m);
    chk("reg_cycles", regc, exp_regc);
    chk("wait_cycles", waitc, exp_waitc);

    // A request offered while the response is pending must not be taken.
    core_req_valid = 1'b1; core_req_instr = $urandom;
    for (int k = 0; k <= rdly; k++) begin
      chk("resp_valid", o.core_resp_valid, 1);
      chk("resp_illegal", o.core_resp_illegal, e_ill);
      chk("resp_timeout", o.core_resp_timeout, e_to);
      chk("resp_we", o.core_resp_we, e_we);
      chk("resp_rd", o.core_resp_rd, instr[11:7]);
      chk("resp_data", o.core_resp_data, e_data);
      core_resp_ready = (k == rdly);
      @(negedge clk);
    end
    core_resp_ready = 1'b0; core_req_valid = 1'b0;
    chk("resp_done_valid", o.core_resp_valid, 0);
    chk("resp_done_idle", o.core_req_ready, 1);
    chk("resp_no_new_issue", o.issue_valid, 0);
  endtask

  task automatic rand_txn(input int n);
    for (int i = 0; i < n; i++)
      run_txn($urandom, $urandom, $urandom, $urandom_range(0, 3) != 0, 1'($urandom),
              2'($urandom), $urandom_range(0, 4), $urandom_range(0, 5), $urandom_range(0, 10),
              $urandom_range(0, 3), $urandom);
  endtask

  initial begin
    rst = 1'b1; sel = 1'b0;
    core_req_valid = 1'b0; core_resp_ready = 1'b0; issue_ready = 1'b0;
    issue_resp_accept = 1'b0; issue_resp_writeback = 1'b0; issue_resp_register_read = '0;
    register_ready = 1'b0; result_valid = 1'b0; result_data = '0;
    core_req_instr = '0; core_req_rs0 = '0; core_req_rs1 = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_resp_valid", o.core_resp_valid, 0);
    chk("rst_issue_valid", o.issue_valid, 0);
    chk("rst_reg_valid", o.register_valid, 0);
    chk("rst_result_ready", o.result_ready, 0);
    chk("rst_issue_instr", o.issue_req_instr, 0);
    chk("rst_resp_data", o.core_resp_data, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_idle_ready", o.core_req_ready, 1);

    // Ready-gated register phase, timeout after T_A cycles.
    run_txn(32'h0000_028B, 32'h1111_0001, 32'h2222_0002, 1, 1, 2'b11, 0, 0, 1, 0, 32'h0000_4000);
    run_txn(32'h0000_0F8B, 32'hA5A5_0000, 32'h5A5A_0000, 1, 1, 2'b01, 10, 1, 0, 0, 32'hDEAD_BEEF);
    run_txn(32'h0000_018B, 32'h3, 32'h4, 0, 1, 2'b11, 1, 0, 0, 1, 32'h1234_5678);
    run_txn(32'h0000_050B, 32'h5, 32'h6, 1, 0, 2'b10, 0, 2, 0, 0, 32'h0);
    run_txn(32'h0000_070B, 32'h7, 32'h8, 1, 1, 2'b11, 0, 20, 0, 0, 32'h0);
    run_txn(32'h0000_090B, 32'h9, 32'hA, 1, 1, 2'b11, 0, 0, T_A - 2, 0, 32'hCAFE_F00D);
    run_txn(32'h0000_0B0B, 32'hB, 32'hC, 1, 1, 2'b11, 0, 0, T_A - 1, 0, 32'hBAD0_BAD0);
    run_txn(32'h0000_0D0B, 32'hD, 32'hE, 1, 1, 2'b11, 0, 0, 0, 4, 32'h0BAD_CAFE);
    rand_txn(20);

    // One-cycle register phase (register_ready never raised), timeout after T_B cycles.
    sel = 1'b1;
    do_reset();
    run_txn(32'h0000_030B, 32'h11, 32'h22, 1, 1, 2'b11, 0, 50, 0, 0, 32'h7777_0000);
    run_txn(32'h0000_058B, 32'h33, 32'h44, 1, 1, 2'b01, 2, 50, 50, 1, 32'h0);
    run_txn(32'h0000_068B, 32'h55, 32'h66, 1, 1, 2'b11, 0, 50, T_B - 2, 0, 32'h8888_0000);
    rand_txn(20);

    // Reset while a transaction is waiting for its result.
    sel = 1'b0;
    do_reset();
    core_req_valid = 1'b1; core_req_instr = 32'h0000_028B; core_req_rs0 = 32'h1; core_req_rs1 = 32'h2;
    @(negedge clk);
    core_req_valid = 1'b0;
    issue_ready = 1'b1; issue_resp_accept = 1'b1; issue_resp_writeback = 1'b1;
    issue_resp_register_read = 2'b11;
    @(negedge clk);
    issue_ready = 1'b0; register_ready = 1'b1;
    @(negedge clk);
    register_ready = 1'b0;
    chk("midrst_in_wait", o.result_ready, 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_result_ready", o.result_ready, 0);
    chk("midrst_resp_valid", o.core_resp_valid, 0);
    chk("midrst_issue_valid", o.issue_valid, 0);
    chk("midrst_reg_valid", o.register_valid, 0);
    chk("midrst_rd", o.core_resp_rd, 0);
    chk("midrst_instr", o.issue_req_instr, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_idle", o.core_req_ready, 1);
    chk("midrst_no_resp", o.core_resp_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
